// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage turning loads/stores into dmem req/ack transactions; `DMEM_TIMEOUT_EN adds a BUSY timeout abort
module mem_access_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              mem_to_reg,
  input  logic              mem_wen,
  input  logic              reg_wen,
  input  logic [REG_AW-1:0] reg_waddr,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic mem_op, busy, done, abort;
  logic req_q, req_d, we_q, we_d, ld_q, ld_d, rwen_q, rwen_d, wbv_q, wbv_d, wbw_q, wbw_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, wbd_q, wbd_d;
  logic [REG_AW-1:0] rwaddr_q, rwaddr_d, wba_q, wba_d;
  assign mem_op = in_valid & (mem_to_reg | mem_wen);
  assign busy = state_q == BUSY;
  assign done = busy & dmem_ack;
`ifdef DMEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign abort = busy & ~dmem_ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  // counter sits at zero in IDLE so it starts clean on every BUSY entry
  always_comb cnt_d = busy ? cnt_q + 8'd1 : 8'd0;
  // timeout counter register
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
`else
  assign abort = 1'b0;
`endif
  assign stall = (~busy & mem_op) | (busy & ~dmem_ack & ~abort);
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state: issue a memory op from IDLE, leave BUSY on ack or timeout
  always_comb state_d = busy ? ((done | abort) ? IDLE : BUSY) : (mem_op ? BUSY : IDLE);
  // outputs: request fields are captured at issue and held; writeback is a bubble unless something completes
  always_comb begin
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    ld_d = ld_q;
    rwen_d = rwen_q;
    rwaddr_d = rwaddr_q;
    wbv_d = 1'b0;
    wbw_d = 1'b0;
    wba_d = wba_q;
    wbd_d = wbd_q;
    err_d = abort;
    if (!busy && mem_op) begin
      req_d = 1'b1;
      we_d = mem_wen;
      addr_d = ADDR_W'(alu_result);
      wdata_d = rdata2;
      ld_d = mem_to_reg & ~mem_wen;
      rwen_d = reg_wen;
      rwaddr_d = reg_waddr;
    end else if (!busy && in_valid) begin
      wbv_d = 1'b1;
      wbw_d = reg_wen;
      wba_d = reg_waddr;
      wbd_d = alu_result;
    end else if (done || abort) begin
      req_d = 1'b0;
      wbv_d = done;
      wbw_d = done & rwen_q;
      wba_d = done ? rwaddr_q : wba_q;
      wbd_d = done ? (ld_q ? dmem_rdata : DATA_W'(addr_q)) : wbd_q;
    end
  end
  // pipeline and request registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ld_q <= 1'b0;
      rwen_q <= 1'b0;
      rwaddr_q <= '0;
      wbv_q <= 1'b0;
      wbw_q <= 1'b0;
      wba_q <= '0;
      wbd_q <= '0;
      err_q <= 1'b0;
    end else begin
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ld_q <= ld_d;
      rwen_q <= rwen_d;
      rwaddr_q <= rwaddr_d;
      wbv_q <= wbv_d;
      wbw_q <= wbw_d;
      wba_q <= wba_d;
      wbd_q <= wbd_d;
      err_q <= err_d;
    end
  end
  assign dmem_req = req_q;
  assign dmem_we = we_q;
  assign dmem_addr = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid = wbv_q;
  assign wb_wen = wbw_q;
  assign wb_waddr = wba_q;
  assign wb_data = wbd_q;
  assign mem_err = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed stimulus with a writeback scoreboard for mem_access_stage
module tb_mem_access_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, mem_to_reg = 0, mem_wen = 0, reg_wen = 0, dmem_ack = 0;
  logic [15:0] alu_result = 0, rdata2 = 0, dmem_rdata = 0;
  logic [3:0] reg_waddr = 0;
  logic stall, dmem_req, dmem_we, wb_valid, wb_wen, mem_err;
  logic [15:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0] wb_waddr;
  int tests = 0, fails = 0;
  typedef struct { logic wen; logic [3:0] waddr; logic [15:0] data; } exp_t;
  exp_t q[$];

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result), .rdata2(rdata2),
    .mem_to_reg(mem_to_reg), .mem_wen(mem_wen), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (q.size() == 0) chk("unexpected_wb_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_wen", wb_wen, e.wen);
        chk("wb_waddr", wb_waddr, e.waddr);
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic drv(input logic iv, ld, st, rw, input logic [3:0] wa, input logic [15:0] alu, d2,
                     input logic ack, input logic [15:0] rd);
    in_valid = iv; mem_to_reg = ld; mem_wen = st; reg_wen = rw; reg_waddr = wa;
    alu_result = alu; rdata2 = d2; dmem_ack = ack; dmem_rdata = rd;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu_op(input logic rw, input logic [3:0] wa, input logic [15:0] alu);
    exp_t e;
    @(posedge clk); #1;
    drv(1, 0, 0, rw, wa, alu, 16'h0, 0, 0);
    e.wen = rw; e.waddr = wa; e.data = alu;
    q.push_back(e);
    @(negedge clk);
    chk("alu_stall", stall, 0);
    chk("alu_noreq", dmem_req, 0);
  endtask

  task automatic memop(input logic ld, st, rw, input logic [3:0] wa, input logic [15:0] alu, d2,
                       input int dly, input logic [15:0] rd);
    exp_t e;
    @(posedge clk); #1;
    drv(1, ld, st, rw, wa, alu, d2, 0, 0);
    @(negedge clk);
    chk("issue_stall", stall, 1);
    chk("issue_noreq", dmem_req, 0);
    for (int i = 1; i <= dly; i++) begin
      @(posedge clk); #1;
      drv(1, ld, st, rw, wa, alu, d2, i == dly, rd);
      @(negedge clk);
      chk("busy_req", dmem_req, 1);
      chk("busy_we", dmem_we, st);
      chk("busy_addr", dmem_addr, alu);
      if (st) chk("busy_wdata", dmem_wdata, d2);
      chk("busy_stall", stall, i != dly);
      chk("busy_mem_err", mem_err, 0);
    end
    e.wen = rw; e.waddr = wa; e.data = (ld && !st) ? rd : alu;
    q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall", stall, 0);
    alu_op(1, 4'd5, 16'h1234);
    idle();
    memop(1, 0, 1, 4'd3, 16'h0040, 16'h0, 3, 16'hBEEF);
    memop(0, 1, 0, 4'd9, 16'h0010, 16'hA5A5, 1, 16'h0);
    memop(1, 0, 1, 4'd1, 16'h0020, 16'h0, 1, 16'h1111);
    memop(1, 0, 1, 4'd2, 16'h0022, 16'h0, 1, 16'h2222);
    alu_op(1, 4'd7, 16'h7777);
    memop(1, 1, 1, 4'd6, 16'h0030, 16'h5A5A, 2, 16'hDEAD);
    idle();
    @(posedge clk); #1;
    drv(1, 1, 0, 1, 4'd8, 16'h0060, 16'h0, 0, 16'h3333);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", dmem_req, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstbusy_req", dmem_req, 0);
    chk("rstbusy_we", dmem_we, 0);
    chk("rstbusy_addr", dmem_addr, 0);
    chk("rstbusy_wdata", dmem_wdata, 0);
    chk("rstbusy_wb_valid", wb_valid, 0);
    chk("rstbusy_wb_wen", wb_wen, 0);
    chk("rstbusy_wb_waddr", wb_waddr, 0);
    chk("rstbusy_wb_data", wb_data, 0);
    chk("rstbusy_stall", stall, 0);
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 0, 0, 0, 1, 16'h3333);
    @(negedge clk);
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_stall", stall, 0);
    idle();
    @(negedge clk);
    chk("late_ack_wb_valid", wb_valid, 0);
`ifdef DMEM_TIMEOUT_EN
    @(posedge clk); #1;
    drv(1, 1, 0, 1, 4'd4, 16'h0050, 16'h0, 0, 0);
    @(negedge clk);
    chk("to_issue_stall", stall, 1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_busy_req", dmem_req, 1);
      chk("to_busy_stall", stall, i != 4);
    end
    idle();
    @(negedge clk);
    chk("to_mem_err", mem_err, 1);
    chk("to_req", dmem_req, 0);
    chk("to_stall", stall, 0);
    chk("to_wb_valid", wb_valid, 0);
    idle();
    @(negedge clk);
    chk("to_mem_err_pulse", mem_err, 0);
`endif
    idle();
    idle();
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the 16-bit pipelined CPU.
- Non-memory instructions pass straight through to the MEM/WB registers.
- Loads and stores become req/ack transactions on the data-memory port.
- Pipeline stalls upstream until the memory acks; results go to writeback as registered MEM/WB outputs.

Parameters:
- DATA_W, 16, data/register width.
- ADDR_W, 16, data-memory address width.
- REG_AW, 4, register-file address width.
- TIMEOUT_CYCLES, 15, maximum BUSY cycles before abort (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- alu_result  in  DATA_W  memory address for ld/st; result for ALU ops
- rdata2  in  DATA_W  store data
- mem_to_reg  in  1  load
- mem_wen  in  1  store
- reg_wen  in  1  register write enable
- reg_waddr  in  REG_AW  destination register
- stall  out  1  combinational; holds EX/MEM and earlier stages
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  request address
- dmem_wdata  out  DATA_W  write data
- dmem_ack  in  1  request completed this cycle
- dmem_rdata  in  DATA_W  read data, valid when dmem_ack = 1
- wb_valid  out  1  MEM/WB slot holds a completed instruction
- wb_wen  out  1  register write enable to WB
- wb_waddr  out  REG_AW  destination register to WB
- wb_data  out  DATA_W  writeback data
- mem_err  out  1  one-cycle timeout abort pulse (DMEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset: state IDLE. dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_wen, wb_waddr, wb_data, mem_err all 0. Reset has priority over everything.
- FSM states: IDLE and BUSY.
- mem_op = in_valid & (mem_to_reg | mem_wen). When both flags are set, the op is a store: no load data, wb_data = alu_result.
- stall = (IDLE & mem_op) | (BUSY & ~dmem_ack).
- IDLE, no mem_op, in_valid = 1 (ALU op):
  - next edge: wb_valid=1, wb_wen=reg_wen, wb_waddr=reg_waddr, wb_data=alu_result.
  - Latency 1 cycle; no stall.
- IDLE, in_valid = 0: next edge wb_valid=0 and wb_wen=0 (bubble).
- IDLE, mem_op:
  - stall=1.
  - next edge: go BUSY; dmem_req=1, dmem_we=mem_wen, dmem_addr=alu_result, dmem_wdata=rdata2.
  - Also latch reg_wen, reg_waddr and the load flag; insert a bubble (wb_valid=0, wb_wen=0).
- BUSY:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until dmem_ack is sampled 1.
  - Inputs are held by stall and are not re-sampled.
- BUSY and dmem_ack=1:
  - stall=0 that cycle.
  - next edge: state IDLE, dmem_req=0, wb_valid=1, wb_wen=latched reg_wen, wb_waddr=latched waddr.
  - wb_data = dmem_rdata for a load, latched alu_result for a store.
- Minimum memory-op latency is 2 cycles: issue cycle plus the ack cycle, with an ack on the first BUSY cycle.
- dmem_ack while IDLE is ignored.
- Back-to-back memory ops: the next op is seen in IDLE on the cycle after the ack and issues normally.
- rst during BUSY:
  - dmem_req drops on the reset edge and the transaction is abandoned; no writeback.
  - The memory side must tolerate the dropped request.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and stall=0 that cycle.
  - dmem_req drops, mem_err pulses 1 for one cycle, and wb_valid/wb_wen stay 0 (instruction squashed).
  - An ack arriving in the same cycle as the timeout wins.
- Undefined: no counter; BUSY waits indefinitely; mem_err is constant 0.

Test Plan:
- ALU op: in_valid=1, alu_result=0x1234, reg_wen=1, reg_waddr=5 -> next cycle wb_valid=1, wb_waddr=5, wb_data=0x1234; stall never 1.
- Load with ack delay 3: alu_result=0x0040, mem_to_reg=1, reg_waddr=3, dmem_rdata=0xBEEF -> dmem_req held 3 cycles with addr 0x0040 and we=0; stall low on the ack cycle; then wb_data=0xBEEF, wb_waddr=3, wb_valid=1.
- Store: mem_wen=1, alu_result=0x0010, rdata2=0xA5A5, reg_wen=0, ack on first BUSY cycle -> dmem_we=1, dmem_wdata=0xA5A5; wb_valid=1 with wb_wen=0.
- Back-to-back load then load, immediate acks, then an ALU op -> two wb_valid pulses separated by bubbles, correct data order, no duplicate request.
- rst asserted during the second BUSY cycle of a load -> next cycle dmem_req=0 and all outputs 0; a later ack is ignored.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never given -> after 4 BUSY cycles: mem_err=1 for one cycle, dmem_req=0, stall=0, no wb_valid.
